wb_mem_2_ppfifo: RTL and testbench
==================================

Name: wb_mem_2_ppfifo

Overview:
- Wishbone master DMA reader that streams words from two host-programmed memory regions into the write side of a ping-pong FIFO.
- It is the read-direction counterpart of the ppfifo-to-memory writer, for display or playback paths.
- Memory regions 0 and 1 are double-buffered: the host refills one region while the other drains.
- Per-region count, finished and empty flags feed a wishbone slave register front end.

Parameters:
- TIMEOUT_COUNT, 32'd1000: cycles to wait for mem_i_ack before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  run enable; 0 halts at the next word boundary.
- i_flush  in  1  pulse; abort the current region and mark both regions empty.
- i_memory_0_base  in  32  region 0 start word address.
- i_memory_0_size  in  32  region 0 length in words.
- i_memory_0_ready  in  1  pulse; latch region 0 base/size, region becomes loaded.
- o_memory_0_count  out  32  words read from region 0.
- o_memory_0_finished  out  1  region 0 fully drained.
- o_memory_0_empty  out  1  region 0 not loaded.
- i_memory_1_base, i_memory_1_size, i_memory_1_ready, o_memory_1_count, o_memory_1_finished, o_memory_1_empty: same as region 0, for region 1.
- o_read_finished  out  1  one-cycle pulse when any region completes.
- o_error  out  1  sticky bus-timeout flag (optional feature only; tied 0 otherwise).
- o_mem_we  out  1  constant 0.
- o_mem_stb  out  1  wishbone strobe.
- o_mem_cyc  out  1  wishbone cycle.
- o_mem_sel  out  4  constant 4'hF.
- o_mem_adr  out  32  word address.
- o_mem_dat  out  32  constant 0.
- i_mem_dat  in  32  read data.
- i_mem_ack  in  1  acknowledge.
- i_mem_int  in  1  unused.
- i_ppfifo_rdy  in  2  write-side buffer ready.
- o_ppfifo_act  out  2  write-side buffer activate.
- i_ppfifo_size  in  24  buffer capacity in words.
- o_ppfifo_stb  out  1  one-cycle write strobe.
- o_ppfifo_data  out  32  write data.

Behaviour:
- Reset values:
  - All outputs 0, except o_memory_0_empty = o_memory_1_empty = 1.
  - State is IDLE, current region is 0, internal base/size latches are 0.
- Region load (i_memory_N_ready):
  - Latches base and size, clears count and finished, clears empty.
  - A size of 0 is ignored and the region stays empty.
  - A ready pulse for the region currently being read is ignored.
- Region selection:
  - Regions alternate 0,1,0,...
  - If the preferred region is empty and the other is loaded, the other is taken.
- States:
  - IDLE: wait for i_enable and at least one loaded region, then go to SELECT.
  - SELECT: pick the region, go to FIFO_GRAB.
  - FIFO_GRAB: when i_ppfifo_rdy != 0 and o_ppfifo_act == 0, assert act on one ready bit (bit 0 has priority), reset the FIFO word counter, go to READ_REQ.
  - READ_REQ: drive cyc=stb=1, adr = base + count; go to READ_WAIT.
  - READ_WAIT: on i_mem_ack:
    - Drop cyc/stb the same edge.
    - Register i_mem_dat to o_ppfifo_data and pulse o_ppfifo_stb.
    - Increment count and the FIFO word counter, go to NEXT.
  - NEXT, evaluated in this order:
    1. count == size: set finished, set empty, pulse o_read_finished, toggle region; go to RELEASE if any words are in the FIFO, else IDLE.
    2. FIFO word counter == i_ppfifo_size: go to RELEASE.
    3. !i_enable: go to RELEASE.
    4. Otherwise go to READ_REQ. cyc/stb are low for at least one cycle between words.
  - RELEASE: clear o_ppfifo_act; go to IDLE if the current region is done, else FIFO_GRAB.
- Throughput: best case is one word per 3 cycles with zero-wait ack.
- A partially filled FIFO buffer is released at region end.
- finished stays high until that region is re-loaded.
- i_flush:
  - Any state: drop cyc/stb, release act.
  - Both regions become empty; counts are held; finished is not set.
  - Go to IDLE next cycle. An ack arriving on the flush cycle is discarded.
- Simultaneous ready pulses for both regions: both latch.
- count is 32-bit; base + count wraps modulo 2^32 with no error.
- rst mid-burst: cyc/stb drop on the next edge; no FIFO strobe.

Optional Feature:
- Macro: WB_MEM_2_PPFIFO_TIMEOUT_EN.
- Enabled:
  - A counter runs in READ_WAIT.
  - If it reaches TIMEOUT_COUNT without an ack, drop cyc/stb and set o_error (sticky until rst or i_flush).
  - The region is treated as finished with its current count, and the FIFO is released.
- Disabled: READ_WAIT waits forever and o_error is tied 0.

Test Plan:
- Load region 0 (base 0x100, size 4); FIFO size 8; zero-wait ack → reads at addresses 0x100..0x103; 4 strobes with matching data; act released after the 4th word; memory_0_finished=1, count=4, one o_read_finished pulse.
- Region 0 size 10, FIFO size 4 → three activations: 4, 4, 2 words; both act bits used alternately.
- Load both regions (size 3 each) → region 0 fully read, then region 1; both finished; empty flags back to 1.
- Ack delayed 5 cycles per word → cyc/stb held until ack; exactly one strobe per ack; no duplicate reads.
- Flush after the 2nd of 6 words → cyc/stb low next cycle; act released; count=2; finished=0; empty=1.
- With WB_MEM_2_PPFIFO_TIMEOUT_EN and TIMEOUT_COUNT=16, ack withheld → abort after 16 cycles; o_error=1; FIFO released.

Source files
------------

// File: rtl/wb_mem_2_ppfifo.sv
// Wishbone DMA reader: drains two double-buffered memory regions into a ping-pong FIFO write port.
// Defining WB_MEM_2_PPFIFO_TIMEOUT_EN adds an ack timeout that aborts the region and raises o_error.
module wb_mem_2_ppfifo #(
  parameter logic [31:0] TIMEOUT_COUNT = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_flush,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_ready,
  output logic [31:0] o_memory_0_count,
  output logic        o_memory_0_finished,
  output logic        o_memory_0_empty,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_ready,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_1_finished,
  output logic        o_memory_1_empty,
  output logic        o_read_finished,
  output logic        o_error,
  output logic        o_mem_we,
  output logic        o_mem_stb,
  output logic        o_mem_cyc,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  input  logic        i_mem_int,
  input  logic [1:0]  i_ppfifo_rdy,
  output logic [1:0]  o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  output logic [31:0] o_ppfifo_data
);
  typedef enum logic [2:0] {
    IDLE, SELECT, FIFO_GRAB, READ_REQ, READ_WAIT, NEXT, RELEASE
  } state_t;

  state_t state, state_n;

  logic [1:0][31:0] base_r, size_r, count_r;
  logic [1:0][31:0] ld_base, ld_size;
  logic [1:0]       ld, finished_r, empty_r, act;
  logic             cur, region_done, cyc, fstb, rd_fin, err;
  logic [23:0]      fifo_cnt;
  logic [31:0]      adr, fdata;
  logic             busy, last_word, tmo_hit, fin_now;
  logic             unused_ok;

  assign ld      = {i_memory_1_ready, i_memory_0_ready};
  assign ld_base = {i_memory_1_base, i_memory_0_base};
  assign ld_size = {i_memory_1_size, i_memory_0_size};

  // A region is "being read" from selection until it finishes; loads to it are dropped.
  assign busy      = (state != IDLE) && !region_done;
  assign last_word = (count_r[cur] == size_r[cur]);

`ifdef WB_MEM_2_PPFIFO_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  assign tmo_hit = (state == READ_WAIT) && !i_mem_ack && (tmo_cnt == TIMEOUT_COUNT - 32'd1);
`else
  assign tmo_hit = 1'b0;
`endif

  assign fin_now   = (state == NEXT && last_word) || tmo_hit;
  assign unused_ok = &{1'b0, i_mem_int, TIMEOUT_COUNT};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (i_enable && (!empty_r[0] || !empty_r[1])) state_n = SELECT;
      SELECT:    state_n = FIFO_GRAB;
      FIFO_GRAB: if (i_enable && i_ppfifo_rdy != 2'b00 && act == 2'b00) state_n = READ_REQ;
      READ_REQ:  state_n = READ_WAIT;
      READ_WAIT: begin
        if (i_mem_ack)    state_n = NEXT;
        else if (tmo_hit) state_n = RELEASE;
      end
      NEXT: begin
        if (last_word)                    state_n = (fifo_cnt != 24'd0) ? RELEASE : IDLE;
        else if (fifo_cnt == i_ppfifo_size) state_n = RELEASE;
        else if (!i_enable)               state_n = RELEASE;
        else                              state_n = READ_REQ;
      end
      RELEASE:   state_n = region_done ? IDLE : FIFO_GRAB;
      default:   state_n = IDLE;
    endcase
    if (i_flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r      <= '0;
      size_r      <= '0;
      count_r     <= '0;
      finished_r  <= 2'b00;
      empty_r     <= 2'b11;
      cur         <= 1'b0;
      region_done <= 1'b0;
      act         <= 2'b00;
      fifo_cnt    <= 24'd0;
      cyc         <= 1'b0;
      adr         <= 32'd0;
      fstb        <= 1'b0;
      fdata       <= 32'd0;
      rd_fin      <= 1'b0;
      err         <= 1'b0;
`ifdef WB_MEM_2_PPFIFO_TIMEOUT_EN
      tmo_cnt     <= 32'd0;
`endif
    end else begin
      fstb   <= 1'b0;
      rd_fin <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (ld[r] && ld_size[r] != 32'd0 && !(busy && cur == r[0])) begin
          base_r[r]     <= ld_base[r];
          size_r[r]     <= ld_size[r];
          count_r[r]    <= 32'd0;
          finished_r[r] <= 1'b0;
          empty_r[r]    <= 1'b0;
        end
      end
      if (i_flush) begin
        // Counts are kept for the host; an ack landing this cycle is dropped.
        cyc     <= 1'b0;
        act     <= 2'b00;
        empty_r <= 2'b11;
        err     <= 1'b0;
      end else begin
        case (state)
          IDLE:   region_done <= 1'b0;
          SELECT: if (empty_r[cur] && !empty_r[~cur]) cur <= ~cur;
          FIFO_GRAB: begin
            if (state_n == READ_REQ) begin
              act      <= i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
              fifo_cnt <= 24'd0;
            end
          end
          READ_REQ: begin
            cyc <= 1'b1;
            adr <= base_r[cur] + count_r[cur];
`ifdef WB_MEM_2_PPFIFO_TIMEOUT_EN
            tmo_cnt <= 32'd0;
`endif
          end
          READ_WAIT: begin
            if (i_mem_ack) begin
              cyc          <= 1'b0;
              fdata        <= i_mem_dat;
              fstb         <= 1'b1;
              count_r[cur] <= count_r[cur] + 32'd1;
              fifo_cnt     <= fifo_cnt + 24'd1;
            end else begin
`ifdef WB_MEM_2_PPFIFO_TIMEOUT_EN
              tmo_cnt <= tmo_cnt + 32'd1;
`endif
              if (tmo_hit) begin
                cyc <= 1'b0;
                err <= 1'b1;
              end
            end
          end
          NEXT:    if (last_word && fifo_cnt == 24'd0) act <= 2'b00;
          RELEASE: act <= 2'b00;
          default: ;
        endcase
        if (fin_now) begin
          finished_r[cur] <= 1'b1;
          empty_r[cur]    <= 1'b1;
          rd_fin          <= 1'b1;
          cur             <= ~cur;
          region_done     <= 1'b1;
        end
      end
    end
  end

  assign o_memory_0_count    = count_r[0];
  assign o_memory_0_finished = finished_r[0];
  assign o_memory_0_empty    = empty_r[0];
  assign o_memory_1_count    = count_r[1];
  assign o_memory_1_finished = finished_r[1];
  assign o_memory_1_empty    = empty_r[1];
  assign o_read_finished     = rd_fin;
  assign o_error             = err;
  assign o_mem_we            = 1'b0;
  assign o_mem_stb           = cyc;
  assign o_mem_cyc           = cyc;
  assign o_mem_sel           = 4'hF;
  assign o_mem_adr           = adr;
  assign o_mem_dat           = 32'd0;
  assign o_ppfifo_act        = act;
  assign o_ppfifo_stb        = fstb;
  assign o_ppfifo_data       = fdata;

endmodule

// File: tb/tb_wb_mem_2_ppfifo.sv
// Scoreboard bench for wb_mem_2_ppfifo: memory model returns adr^0xDEAD0000, monitor checks FIFO strobes.
module tb_wb_mem_2_ppfifo;
  logic        clk = 1'b0;
  logic        rst, enable, flush;
  logic [31:0] m0_base, m0_size, m1_base, m1_size;
  logic        m0_rdy, m1_rdy;
  logic [31:0] m0_count, m1_count;
  logic        m0_fin, m0_empty, m1_fin, m1_empty;
  logic        read_finished, error;
  logic        mem_we, mem_stb, mem_cyc;
  logic [3:0]  mem_sel;
  logic [31:0] mem_adr, mem_dat_o, mem_dat_i;
  logic        mem_ack, mem_int;
  logic [1:0]  pp_rdy, pp_act;
  logic [23:0] pp_size;
  logic        pp_stb;
  logic [31:0] pp_data;

  int total = 0, bad = 0;
  int ack_delay = 0, wait_cnt = 0;
  logic ack_hold = 1'b0;
  int stb_cnt, acks, reads, cyc_hi, fin_pulses;
  int use_cnt[2];
  int busy_cnt[2];
  logic cyc_q = 1'b0;
  logic [1:0] act_q = 2'b00;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_mem_2_ppfifo #(.TIMEOUT_COUNT(32'd16)) dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_flush(flush),
    .i_memory_0_base(m0_base), .i_memory_0_size(m0_size), .i_memory_0_ready(m0_rdy),
    .o_memory_0_count(m0_count), .o_memory_0_finished(m0_fin), .o_memory_0_empty(m0_empty),
    .i_memory_1_base(m1_base), .i_memory_1_size(m1_size), .i_memory_1_ready(m1_rdy),
    .o_memory_1_count(m1_count), .o_memory_1_finished(m1_fin), .o_memory_1_empty(m1_empty),
    .o_read_finished(read_finished), .o_error(error),
    .o_mem_we(mem_we), .o_mem_stb(mem_stb), .o_mem_cyc(mem_cyc), .o_mem_sel(mem_sel),
    .o_mem_adr(mem_adr), .o_mem_dat(mem_dat_o), .i_mem_dat(mem_dat_i), .i_mem_ack(mem_ack),
    .i_mem_int(mem_int), .i_ppfifo_rdy(pp_rdy), .o_ppfifo_act(pp_act),
    .i_ppfifo_size(pp_size), .o_ppfifo_stb(pp_stb), .o_ppfifo_data(pp_data)
  );

  // Wishbone slave: ack after ack_delay wait cycles, data derived from address.
  assign mem_ack   = mem_cyc && mem_stb && !ack_hold && (wait_cnt >= ack_delay);
  assign mem_dat_i = mem_adr ^ 32'hDEAD_0000;
  always @(posedge clk) begin
    if (mem_cyc && mem_stb && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                                wait_cnt <= 0;
  end

  // FIFO reader model: a buffer is unavailable while active and for 6 cycles after release.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pp_rdy[i] <= 1'b1; busy_cnt[i] <= 0;
      end else if (pp_act[i]) begin
        pp_rdy[i] <= 1'b0; busy_cnt[i] <= 6;
      end else if (busy_cnt[i] != 0) begin
        busy_cnt[i] <= busy_cnt[i] - 1;
      end else begin
        pp_rdy[i] <= 1'b1;
      end
    end
  end

  // Monitor: pop the scoreboard on every FIFO strobe and count bus activity.
  always @(negedge clk) begin
    if (pp_stb) begin
      stb_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected got=%h exp=<none>", pp_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pp_data !== e || pp_act == 2'b00) begin
          bad++;
          $display("FAIL strobe_data got=%h act=%b exp=%h act!=0", pp_data, pp_act, e);
        end
      end
    end
    if (mem_ack) acks++;
    if (mem_cyc && !cyc_q) reads++;
    if (mem_cyc) cyc_hi++;
    if (read_finished) fin_pulses++;
    for (int i = 0; i < 2; i++) if (pp_act[i] && !act_q[i]) use_cnt[i]++;
    cyc_q = mem_cyc;
    act_q = pp_act;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic clr_counts();
    @(posedge clk);
    stb_cnt = 0; acks = 0; reads = 0; cyc_hi = 0; fin_pulses = 0;
    use_cnt[0] = 0; use_cnt[1] = 0;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back((base + 32'(k)) ^ 32'hDEAD_0000);
  endtask

  task automatic load(input int r, input logic [31:0] b, input logic [31:0] s);
    @(negedge clk);
    if (r == 0) begin m0_base = b; m0_size = s; m0_rdy = 1'b1; end
    else        begin m1_base = b; m1_size = s; m1_rdy = 1'b1; end
    @(negedge clk);
    m0_rdy = 1'b0; m1_rdy = 1'b0;
  endtask

  task automatic wait_fin(input int n, input int budget, input string name);
    int k = 0;
    while (fin_pulses < n && k < budget) begin @(negedge clk); k++; end
    chk(name, 32'(fin_pulses), 32'(n));
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; mem_int = 1'b0;
    m0_base = 0; m0_size = 0; m1_base = 0; m1_size = 0; m0_rdy = 0; m1_rdy = 0;
    pp_size = 24'd8;
    stb_cnt = 0; acks = 0; reads = 0; cyc_hi = 0; fin_pulses = 0;
    use_cnt[0] = 0; use_cnt[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(mem_cyc), 0);
    chk("rst_act", 32'(pp_act), 0);
    chk("rst_empty", {30'd0, m1_empty, m0_empty}, 32'd3);
    chk("rst_fin", {30'd0, m1_fin, m0_fin}, 0);
    chk("rst_count0", m0_count, 0);
    chk("rst_misc", {27'd0, mem_we, mem_sel}, 32'h0F);
    rst = 1'b0; enable = 1'b1;

    // 1: single region fits one FIFO buffer
    clr_counts();
    push_exp(32'h100, 4);
    load(0, 32'h100, 32'd4);
    wait_fin(1, 300, "t1_finish");
    chk("t1_count0", m0_count, 32'd4);
    chk("t1_fin_empty0", {30'd0, m0_fin, m0_empty}, 32'd3);
    chk("t1_act_released", 32'(pp_act), 0);
    chk("t1_strobes", 32'(stb_cnt), 32'd4);
    chk("t1_fin_pulses", 32'(fin_pulses), 32'd1);

    // 2: region larger than FIFO buffer -> 4,4,2 over alternating buffers
    clr_counts();
    pp_size = 24'd4;
    push_exp(32'h2000, 10);
    load(0, 32'h2000, 32'd10);
    wait_fin(1, 500, "t2_finish");
    chk("t2_count0", m0_count, 32'd10);
    chk("t2_use_buf0", 32'(use_cnt[0]), 32'd2);
    chk("t2_use_buf1", 32'(use_cnt[1]), 32'd1);
    chk("t2_acks", 32'(acks), 32'd10);

    // 3: zero-size ignored, then both regions loaded together; region 1 wraps
    do_reset();
    pp_size = 24'd8;
    clr_counts();
    load(0, 32'h3000, 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_zero_size_empty", 32'(m0_empty), 32'd1);
    chk("t3_zero_size_idle", 32'(reads), 0);
    push_exp(32'h300, 3);
    push_exp(32'hFFFF_FFFF, 3);
    @(negedge clk);
    m0_base = 32'h300; m0_size = 3; m1_base = 32'hFFFF_FFFF; m1_size = 3;
    m0_rdy = 1'b1; m1_rdy = 1'b1;
    @(negedge clk);
    m0_rdy = 1'b0; m1_rdy = 1'b0;
    wait_fin(2, 500, "t3_finish");
    chk("t3_counts", {m1_count[15:0], m0_count[15:0]}, 32'h0003_0003);
    chk("t3_flags", {28'd0, m1_fin, m1_empty, m0_fin, m0_empty}, 32'hF);

    // 4: 5-cycle ack latency, one read per word
    clr_counts();
    ack_delay = 5;
    push_exp(32'h400, 3);
    load(0, 32'h400, 32'd3);
    wait_fin(1, 500, "t4_finish");
    chk("t4_reads", 32'(reads), 32'd3);
    chk("t4_acks", 32'(acks), 32'd3);
    chk("t4_strobes", 32'(stb_cnt), 32'd3);
    chk("t4_cyc_hold", 32'(cyc_hi), 32'd18);
    ack_delay = 0;

    // 5: flush while the third word's ack is on the bus
    clr_counts();
    push_exp(32'h500, 2);
    load(1, 32'h500, 32'd6);
    k = 0;
    while (stb_cnt < 2 && k < 200) begin @(negedge clk); k++; end
    chk("t5_two_words", 32'(stb_cnt), 32'd2);
    k = 0;
    while (!mem_cyc && k < 50) begin @(negedge clk); k++; end
    chk("t5_cyc_before_flush", 32'(mem_cyc), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_cyc_dropped", 32'(mem_cyc), 0);
    chk("t5_act_released", 32'(pp_act), 0);
    repeat (6) @(negedge clk);
    chk("t5_count1", m1_count, 32'd2);
    chk("t5_flags1", {30'd0, m1_fin, m1_empty}, 32'd1);
    chk("t5_empty0", 32'(m0_empty), 32'd1);
    chk("t5_no_extra_strobe", 32'(stb_cnt), 32'd2);

`ifdef WB_MEM_2_PPFIFO_TIMEOUT_EN
    // 6: ack withheld -> abort after 16 wait cycles
    clr_counts();
    ack_hold = 1'b1;
    load(0, 32'h600, 32'd4);
    k = 0;
    while (!error && k < 200) begin @(negedge clk); k++; end
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_wait_cycles", 32'(cyc_hi), 32'd16);
    repeat (4) @(negedge clk);
    chk("t6_released", {30'd0, pp_act}, 0);
    chk("t6_cyc_low", 32'(mem_cyc), 0);
    chk("t6_fin0_count0", {m0_count[15:0], 15'd0, m0_fin}, 32'd1);
    ack_hold = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("t6_error_cleared", 32'(error), 0);
`else
    chk("error_tied_low", 32'(error), 0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
